// File: rtl/axi_ram_slave_if.sv
// AXI3 read/write channel bundle between a master and the RAM responder.
// Only INCR bursts of 4-byte beats are carried, so size/burst/lock fields are absent.
interface axi_ram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI3 RAM responder: independent read and write FSMs over one word array.
// Define AXI_SLAVE_DELAY_EN to insert READ_DELAY wait cycles before each read burst.
module axi_ram_slave #(
    parameter int ADDR_WIDTH = 16,
    parameter int READ_DELAY = 4
) (
    input  logic            clk,
    input  logic            rst,
    axi_ram_slave_if.slave  bus
);

`ifdef AXI_SLAVE_DELAY_EN
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
`else
    typedef enum logic [1:0] {R_IDLE, R_BURST} r_state_t;
`endif
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [2**ADDR_WIDTH];

    r_state_t              r_state, r_state_nx;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [3:0]            r_cnt;
    logic [3:0]            r_id;
    logic                  ar_rdy, r_vld;
    logic                  ar_fire, r_fire;

    w_state_t              w_state, w_state_nx;
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [3:0]            w_cnt;
    logic [3:0]            w_id;
    logic                  w_err;
    logic                  aw_rdy, w_rdy, b_vld;
    logic                  aw_fire, w_fire, b_fire;
    logic                  w_final, w_mismatch;

`ifdef AXI_SLAVE_DELAY_EN
    logic [15:0]           r_dly;
`else
    localparam int unused_read_delay = READ_DELAY;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.araddr[31:ADDR_WIDTH+2], bus.araddr[1:0],
                                bus.awaddr[31:ADDR_WIDTH+2], bus.awaddr[1:0]};

    assign ar_fire = bus.arvalid & ar_rdy;
    assign r_fire  = r_vld & bus.rready;
    assign aw_fire = bus.awvalid & aw_rdy;
    assign w_fire  = bus.wvalid & w_rdy;
    assign b_fire  = b_vld & bus.bready;

    assign w_final    = (w_cnt == 4'd0);
    assign w_mismatch = bus.wlast != w_final;

    assign bus.arready = ar_rdy;
    assign bus.rvalid  = r_vld;
    assign bus.rid     = r_id;
    assign bus.rdata   = mem[r_ptr];
    assign bus.rresp   = 2'b00;
    assign bus.rlast   = r_vld & (r_cnt == 4'd0);

    assign bus.awready = aw_rdy;
    assign bus.wready  = w_rdy;
    assign bus.bvalid  = b_vld;
    assign bus.bid     = w_id;
    assign bus.bresp   = (b_vld & w_err) ? 2'b10 : 2'b00;

    // Read FSM next state and handshake outputs.
    always_comb begin
        r_state_nx = r_state;
        ar_rdy     = 1'b0;
        r_vld      = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                ar_rdy = 1'b1;
                if (bus.arvalid) begin
`ifdef AXI_SLAVE_DELAY_EN
                    r_state_nx = (READ_DELAY == 0) ? R_BURST : R_WAIT;
`else
                    r_state_nx = R_BURST;
`endif
                end
            end
`ifdef AXI_SLAVE_DELAY_EN
            R_WAIT: begin
                if (r_dly == 16'd0) r_state_nx = R_BURST;
            end
`endif
            R_BURST: begin
                r_vld = 1'b1;
                if (bus.rready && r_cnt == 4'd0) r_state_nx = R_IDLE;
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    // Read FSM state, burst pointer, beat counter and latched ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_id    <= '0;
`ifdef AXI_SLAVE_DELAY_EN
            r_dly   <= '0;
`endif
        end else begin
            r_state <= r_state_nx;
            if (ar_fire) begin
                r_id  <= bus.arid;
                r_ptr <= bus.araddr[ADDR_WIDTH+1:2];
                r_cnt <= bus.arlen;
            end else if (r_fire) begin
                r_ptr <= r_ptr + 1'b1;
                r_cnt <= r_cnt - 1'b1;
            end
`ifdef AXI_SLAVE_DELAY_EN
            if (ar_fire)
                r_dly <= 16'(READ_DELAY - 1);
            else if (r_state == R_WAIT && r_dly != 16'd0)
                r_dly <= r_dly - 1'b1;
`endif
        end
    end

    // Write FSM next state and handshake outputs.
    always_comb begin
        w_state_nx = w_state;
        aw_rdy     = 1'b0;
        w_rdy      = 1'b0;
        b_vld      = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                aw_rdy = 1'b1;
                if (bus.awvalid) w_state_nx = W_DATA;
            end
            W_DATA: begin
                w_rdy = 1'b1;
                if (bus.wvalid && w_final) w_state_nx = W_RESP;
            end
            W_RESP: begin
                b_vld = 1'b1;
                if (bus.bready) w_state_nx = W_IDLE;
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    // Write FSM state, pointer, counter, ID and sticky wlast error.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_ptr   <= '0;
            w_cnt   <= '0;
            w_id    <= '0;
            w_err   <= 1'b0;
        end else begin
            w_state <= w_state_nx;
            if (aw_fire) begin
                w_id  <= bus.awid;
                w_ptr <= bus.awaddr[ADDR_WIDTH+1:2];
                w_cnt <= bus.awlen;
            end else if (w_fire) begin
                w_ptr <= w_ptr + 1'b1;
                w_cnt <= w_cnt - 1'b1;
            end
            if (w_fire && w_mismatch)
                w_err <= 1'b1;
            else if (b_fire)
                w_err <= 1'b0;
        end
    end

    // Byte-lane write into the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_fire && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) mem[w_ptr][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed self-checking bench for axi_ram_slave.
// Define AXI_SLAVE_DELAY_EN here too when the DUT is built with the read delay.
module tb_axi_ram_slave;

`ifdef AXI_SLAVE_DELAY_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] exp_data [16];
    logic [31:0] wbuf [16];

    axi_ram_slave_if bus();

    axi_ram_slave dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_rvalid(output int waited);
        waited = 0;
        while (bus.rvalid !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic read_burst(input logic [31:0] addr, input int len,
                              input logic [3:0] id);
        int w;
        @(negedge clk);
        bus.araddr  = addr;
        bus.arlen   = 4'(len);
        bus.arid    = id;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        check("arready", 32'(bus.arready), 32'd1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        wait_rvalid(w);
        check("r_latency", 32'(w), 32'(LAT));
        for (int i = 0; i <= len; i++) begin
            check("rvalid", 32'(bus.rvalid), 32'd1);
            check("rdata", bus.rdata, exp_data[i]);
            check("rid", 32'(bus.rid), 32'(id));
            check("rlast", 32'(bus.rlast), 32'(i == len));
            check("rresp", 32'(bus.rresp), 32'd0);
            @(negedge clk);
        end
        check("r_done_rvalid", 32'(bus.rvalid), 32'd0);
        check("r_done_arready", 32'(bus.arready), 32'd1);
    endtask

    task automatic write_burst(input logic [31:0] addr, input int len,
                               input logic [3:0] id, input logic [3:0] strb,
                               input int last_beat, input logic [1:0] resp);
        @(negedge clk);
        bus.awaddr  = addr;
        bus.awlen   = 4'(len);
        bus.awid    = id;
        bus.awvalid = 1'b1;
        check("awready", 32'(bus.awready), 32'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            check("wready", 32'(bus.wready), 32'd1);
            bus.wvalid = 1'b1;
            bus.wdata  = wbuf[i];
            bus.wstrb  = strb;
            bus.wlast  = (i == last_beat);
            @(negedge clk);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        check("wready_off", 32'(bus.wready), 32'd0);
        check("bvalid", 32'(bus.bvalid), 32'd1);
        check("bid", 32'(bus.bid), 32'(id));
        check("bresp", 32'(bus.bresp), 32'(resp));
        @(negedge clk);
        check("bvalid_hold", 32'(bus.bvalid), 32'd1);
        check("bresp_hold", 32'(bus.bresp), 32'(resp));
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        check("bvalid_off", 32'(bus.bvalid), 32'd0);
        check("awready_back", 32'(bus.awready), 32'd1);
    endtask

    initial begin
        int w;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        for (int i = 0; i < 16; i++) dut.mem[16'h40 + i] = 32'h40 + i;
        dut.mem[16'h90] = 32'h1122_3344;

        repeat (3) @(negedge clk);
        check("rst_arready", 32'(bus.arready), 32'd1);
        check("rst_awready", 32'(bus.awready), 32'd1);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("rst_rlast", 32'(bus.rlast), 32'd0);
        check("rst_wready", 32'(bus.wready), 32'd0);
        check("rst_bvalid", 32'(bus.bvalid), 32'd0);
        check("rst_rid", 32'(bus.rid), 32'd0);
        check("rst_bid", 32'(bus.bid), 32'd0);
        check("rst_bresp", 32'(bus.bresp), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) exp_data[i] = 32'h40 + i;
        read_burst(32'h100, 15, 4'd3);

        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
        write_burst(32'h200, 3, 4'd5, 4'hF, 3, 2'b00);
        for (int i = 0; i < 4; i++) exp_data[i] = 32'hA0 + i;
        read_burst(32'h200, 3, 4'd1);

        wbuf[0] = 32'hAABB_CCDD;
        write_burst(32'h240, 0, 4'd2, 4'b0101, 0, 2'b00);
        exp_data[0] = 32'h11BB_33DD;
        read_burst(32'h240, 0, 4'd2);

        @(negedge clk);
        bus.araddr = 32'h100; bus.arlen = 4'd1; bus.arid = 4'd7;
        bus.arvalid = 1'b1; bus.rready = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        wait_rvalid(w);
        check("stall_b0", bus.rdata, 32'h40);
        check("stall_b0_last", 32'(bus.rlast), 32'd0);
        @(negedge clk);
        bus.rready = 1'b0;
        check("stall_b1", bus.rdata, 32'h41);
        check("stall_b1_last", 32'(bus.rlast), 32'd1);
        @(negedge clk);
        check("stall_hold_vld", 32'(bus.rvalid), 32'd1);
        check("stall_hold_data", bus.rdata, 32'h41);
        check("stall_hold_last", 32'(bus.rlast), 32'd1);
        @(negedge clk);
        bus.rready = 1'b1;
        check("stall_hold2_data", bus.rdata, 32'h41);
        @(negedge clk);
        check("stall_done", 32'(bus.rvalid), 32'd0);

        wbuf[0] = 32'hB0; wbuf[1] = 32'hB1;
        write_burst(32'h300, 1, 4'd9, 4'hF, 0, 2'b10);
        exp_data[0] = 32'hB0; exp_data[1] = 32'hB1;
        read_burst(32'h300, 1, 4'd4);
        wbuf[0] = 32'hC0;
        write_burst(32'h310, 0, 4'd10, 4'hF, 0, 2'b00);

        @(negedge clk);
        bus.araddr = 32'h100; bus.arlen = 4'd7; bus.arid = 4'd8;
        bus.arvalid = 1'b1; bus.rready = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        wait_rvalid(w);
        for (int i = 0; i < 3; i++) begin
            check("pre_rst_data", bus.rdata, 32'h40 + i);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("mid_rst_arready", 32'(bus.arready), 32'd1);
        check("mid_rst_rid", 32'(bus.rid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) exp_data[i] = 32'h40 + i;
        read_burst(32'h100, 7, 4'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_ram_slave.md
# axi_ram_slave

AXI3 responder modelling main memory: it accepts the burst reads and writes the CPU's arbitrater issues and answers them from an internal word array. It is the far end of the CPU's external AXI port and replaces the external RAM in simulation-level system benches. Read and write channels run independent state machines, each with one outstanding transaction, and both share one memory array.

## Interface
- ADDR_WIDTH, 16: word-address bits; the array holds 2^ADDR_WIDTH 32-bit words.
- READ_DELAY, 4: extra cycles before the first read beat; used only when AXI_SLAVE_DELAY_EN is defined.
- clk  in  1  clock; one clock domain; everything updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- arid  in  4  read ID.
- araddr  in  32  read byte address; bits [1:0] ignored.
- arlen  in  4  beats minus 1.
- arvalid  in  1  read request valid.
- arready  out  1  read request accepted.
- rid  out  4  ID of the current read burst.
- rdata  out  32  read beat data.
- rresp  out  2  always 2'b00 (OKAY).
- rlast  out  1  final read beat.
- rvalid  out  1  read beat valid.
- rready  in  1  master accepts the read beat.
- awid  in  4  write ID.
- awaddr  in  32  write byte address; bits [1:0] ignored.
- awlen  in  4  beats minus 1.
- awvalid  in  1  write request valid.
- awready  out  1  write request accepted.
- wdata  in  32  write beat data.
- wstrb  in  4  byte-lane enables.
- wlast  in  1  master marks the final beat.
- wvalid  in  1  write beat valid.
- wready  out  1  slave accepts the write beat.
- bid  out  4  ID of the completed write.
- bresp  out  2  2'b00 OKAY, or 2'b10 SLVERR on a wlast mismatch.
- bvalid  out  1  write response valid.
- bready  in  1  master accepts the response.

## Operation
- Read FSM states are R_IDLE, R_WAIT (only with the macro) and R_BURST.
  - arready = 1 in R_IDLE.
  - On arvalid&arready: latch arid, word pointer araddr[ADDR_WIDTH+1:2], and beat counter = arlen.
  - In R_BURST: rvalid = 1, rdata = mem[ptr], and rlast = (counter == 0).
  - On rvalid&rready: ptr+1 (wraps modulo 2^ADDR_WIDTH) and counter−1. If rlast, return to R_IDLE.
- Write FSM states are W_IDLE, W_DATA and W_RESP.
  - awready = 1 in W_IDLE. On the handshake, latch awid, pointer and awlen.
  - In W_DATA: wready = 1. On each wvalid&wready, write each byte lane i of mem[ptr] where wstrb[i] = 1, then ptr+1.
  - The burst ends on the beat where counter == 0, regardless of wlast. A wlast value on any beat that disagrees with (counter == 0) sets a sticky error flag.
  - After the final beat, move to W_RESP: bvalid = 1, bid = latched ID, bresp = error flag ? 2'b10 : 2'b00.
  - On bready, return to W_IDLE and clear the error flag.
- Burst type, size, lock, cache, prot and wid are not ports. Every burst is INCR with 4-byte beats.
- The memory array has no reset and no initial contents requirement. Benches preload it hierarchically.

## Timing
- During and after reset:
  - Read FSM is in R_IDLE, write FSM in W_IDLE.
  - arready = awready = 1.
  - rvalid, rlast, wready, bvalid = 0. rid, bid, rresp, bresp = 0. rdata is don't-care.
- Reset mid-burst aborts both FSMs immediately and retains memory contents.
- Read latency (macro off): AR handshake at cycle N gives the first rvalid at N+1. With rready held high, one beat per cycle; arlen=15 completes at N+16.
- Write: AW handshake at N gives wready at N+1. Beats are accepted one per cycle while wvalid is high. bvalid comes the cycle after the final beat and holds until bready.
- rvalid/rdata/rlast hold stable while rready = 0. bvalid/bid/bresp hold stable while bready = 0.
- A new AR/AW is accepted no earlier than the cycle after the previous burst's final handshake, because the ready signal is decoded from the IDLE state.
- Same-cycle read beat and write beat to the same word: the read returns the old data. The write is visible from the next cycle.

## Configuration
- AXI_SLAVE_DELAY_EN defined: after the AR handshake the read FSM enters R_WAIT for READ_DELAY cycles before R_BURST. The first rvalid arrives at N+1+READ_DELAY. READ_DELAY=0 skips R_WAIT.
- AXI_SLAVE_DELAY_EN undefined: no R_WAIT state or delay counter; behaviour as under Timing.

## Test plan
- Preload mem[0x40..0x4F] = index values; AR araddr=0x100, arlen=15, arid=3, rready=1 -> 16 beats of 0x40..0x4F, rid=3 throughout, rlast only on beat 16.
- AW awaddr=0x200, awlen=3, awid=5; four beats 0xA0..0xA3, wlast on beat 4 -> bvalid with bid=5, bresp=00; a following read of 0x200 returns 0xA0..0xA3.
- Word holds 0x11223344; single-beat write of wdata=0xAABBCCDD with wstrb=4'b0101 -> read returns 0x11BB33DD.
- Read with rready toggled 1,0,0,1 -> rdata/rlast stable while stalled, pointer advances only on handshakes.
- awlen=1 with wlast asserted on beat 1 -> two beats written, bresp=2'b10. Next write with correct wlast -> bresp=2'b00.
- Assert rst in the middle of an arlen=7 read -> rvalid=0 the next cycle, arready=1. A new read returns correct data from the beginning of its burst.
